counter_wrap_monitor: RTL and testbench
=======================================

Name: counter_wrap_monitor

Overview:
- Downstream consumer of the 4-bit up/down counter output: samples the count value and direction every clock and classifies each step.
- Detects wrap-up (15->0), wrap-down (0->15) and direction changes; keeps a saturating net wrap tally.
- Queues classified events in a small FIFO drained by a valid/ready handshake toward the logging/scoreboard stage.

Parameters:
- DEPTH, 4, event FIFO entries; power of two, 2..16
- WRAP_W, 8, width of the wrap tally; saturates, never rolls over

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- din  input  4  counter value being monitored
- up_in  input  1  counter direction (1=up, 0=down), sampled with din
- sample_en  input  1  din/up_in valid this cycle
- evt_valid  output  1  FIFO head holds an event
- evt_ready  input  1  consumer accepts head when evt_valid=1
- evt_code  output  2  00 wrap-up, 01 wrap-down, 10 direction change, 11 jump error
- evt_value  output  4  din at the sample that raised the event
- wrap_cnt  output  WRAP_W  net wrap tally: +1 per wrap-up, -1 per wrap-down, saturating
- evt_drop  output  1  sticky; set when an event is lost to a full FIFO
- fifo_level  output  clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; prev_val=0; prev_up=0; FIFO empty; evt_valid=0; evt_code=0; evt_value=0; wrap_cnt=0; evt_drop=0; fifo_level=0.
- Reset asserted mid-operation flushes all pending events immediately. Deassertion is synchronised internally; the first sample is taken no earlier than the second rising edge after release.
- FSM:
  - IDLE: first sample_en=1 loads prev_val/prev_up, raises no event, goes to TRACK.
  - TRACK: each sample_en=1 compares din with prev_val and up_in with prev_up, then updates both.
  - sample_en=0 holds state and history.
- Classification (per sample in TRACK):
  - wrap-up: prev_val=15 and din=0.
  - wrap-down: prev_val=0 and din=15.
  - direction change: up_in != prev_up.
  - A direction change may coincide with a wrap. Enqueue the wrap event first, then the direction event in the same cycle. This takes two FIFO slots; if only one is free, the wrap event wins and evt_drop is set.
  - din == prev_val is a hold and raises no event.
- Event latency: event is visible at the FIFO head (evt_valid=1) on the cycle after the triggering sample edge, when the FIFO was empty.
- FIFO:
  - First-word-fall-through. Head pops on a cycle with evt_valid & evt_ready.
  - evt_code/evt_value hold stable while evt_valid=1 and evt_ready=0.
  - Simultaneous push and pop on a full FIFO is accepted with no drop.
  - Push into a full FIFO without a pop discards the event and sets evt_drop; evt_drop clears only on reset.
- wrap_cnt: two's-complement signed. Saturates at +(2^(WRAP_W-1)-1) and -(2^(WRAP_W-1)). Updates on the edge of the sample, independent of FIFO fullness.

Optional Feature:
- Macro JUMP_CHECK_EN.
- Defined: in TRACK, any step where din is not prev_val, prev_val+1 or prev_val-1 (mod 16) enqueues code 11 with evt_value=din. Wrap steps are still legal ±1 steps. Jump and direction change on the same sample enqueue the jump first, under the same two-slot rule as wraps.
- Undefined: code 11 is never produced, and no jump comparison logic is synthesised.

Test Plan:
- Reset mid-queue: push 3 events, assert rst=0 for 2 cycles -> fifo_level=0, evt_valid=0, wrap_cnt=0, evt_drop=0 immediately; first post-reset sample raises no event.
- Up sweep 13,14,15,0,1 with up_in=1, evt_ready=1 -> exactly one event, code 00, value 0, one cycle after the 15->0 edge; wrap_cnt=1.
- Down sweep 1,0,15,14 with up_in=0 from wrap_cnt=1 -> one event, code 01, value 15; wrap_cnt=0.
- Backpressure, DEPTH=4: hold evt_ready=0 and generate 5 wraps -> fifo_level=4, evt_drop=1, head code/value stable; release -> 4 pops in order.
- Coincident events: prev 15/up, then din=0 with up_in=0 -> codes 00 then 10, both value 0. Repeat with one free slot -> only 00 queued, evt_drop=1.
- JUMP_CHECK_EN defined: 3 -> 9 -> event code 11, value 9. Undefined: same stimulus -> no event.

Source files
------------

// File: rtl/counter_wrap_monitor.sv
// Monitors a 4-bit up/down counter stream, classifies wraps and direction changes,
// and queues events in a FWFT FIFO. Define JUMP_CHECK_EN to also flag non-unit steps.
module counter_wrap_monitor #(
    parameter int DEPTH  = 4,
    parameter int WRAP_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [3:0]               din,
    input  logic                     up_in,
    input  logic                     sample_en,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [1:0]               evt_code,
    output logic [3:0]               evt_value,
    output logic [WRAP_W-1:0]        wrap_cnt,
    output logic                     evt_drop,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    localparam logic [1:0] CODE_WRAP_UP = 2'b00;
    localparam logic [1:0] CODE_WRAP_DN = 2'b01;
    localparam logic [1:0] CODE_DIR     = 2'b10;
    localparam logic [1:0] CODE_JUMP    = 2'b11;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] TRACK = 1'b1;

    localparam logic [WRAP_W-1:0] WRAP_MAX = {1'b0, {(WRAP_W-1){1'b1}}};
    localparam logic [WRAP_W-1:0] WRAP_MIN = {1'b1, {(WRAP_W-1){1'b0}}};

    typedef struct packed {
        logic [1:0] code;
        logic [3:0] value;
    } evt_t;

    // Reset asserts asynchronously but releases two edges later, in step with clk.
    logic [1:0] rst_pipe;
    logic       rst_int;

    // NOTE: sequential state always uses non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_pipe <= 2'b00;
        end else begin
            rst_pipe <= {rst_pipe[0], 1'b1};
        end
    end

    assign rst_int = rst_pipe[1];

    logic [0:0]        state;
    logic [3:0]        prev_val;
    logic              prev_up;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [WRAP_W-1:0] wrap_q;
    logic              drop_q;
    logic [LW-1:0]     level_q;
    evt_t              mem [DEPTH];

    logic       sample_trk;
    logic       is_hold;
    logic       wrap_up;
    logic       wrap_dn;
    logic       dir_chg;
    logic       jump;
    logic       first_vld;
    evt_t       first_evt;
    evt_t       slot0;
    evt_t       slot1;
    logic [1:0] n_evt;
    logic [1:0] n_push;
    logic       pop;
    logic       drop_now;
    logic [LW-1:0] free_slots;

    assign sample_trk = sample_en && (state == TRACK);
    assign is_hold    = (din == prev_val);
    assign wrap_up    = sample_trk && (prev_val == 4'hF) && (din == 4'h0);
    assign wrap_dn    = sample_trk && (prev_val == 4'h0) && (din == 4'hF);
    assign dir_chg    = sample_trk && !is_hold && (up_in != prev_up);

`ifdef JUMP_CHECK_EN
    // A wrap is a legal +/-1 step modulo 16, so it never counts as a jump.
    assign jump = sample_trk && !is_hold &&
                  (din != prev_val + 4'd1) && (din != prev_val - 4'd1);
`else
    assign jump = 1'b0;
`endif

    assign first_vld = wrap_up || wrap_dn || jump;

    // NOTE: every signal driven in always_comb gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        first_evt.value = din;
        first_evt.code  = CODE_WRAP_UP;
        if (jump) begin
            first_evt.code = CODE_JUMP;
        end else if (wrap_dn) begin
            first_evt.code = CODE_WRAP_DN;
        end
    end

    // The wrap/jump event always occupies the earlier slot so it survives a
    // single free entry ahead of the direction event.
    always_comb begin
        slot0 = first_evt;
        slot1 = '{code: CODE_DIR, value: din};
        n_evt = 2'd0;
        if (first_vld) begin
            n_evt = dir_chg ? 2'd2 : 2'd1;
        end else if (dir_chg) begin
            slot0 = '{code: CODE_DIR, value: din};
            n_evt = 2'd1;
        end
    end

    assign pop        = evt_valid && evt_ready;
    assign free_slots = LW'(DEPTH) - level_q + LW'(pop);
    assign drop_now   = (LW'(n_evt) > free_slots);

    always_comb begin
        n_push = n_evt;
        if (drop_now) begin
            n_push = free_slots[1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_int) begin
        if (!rst_int) begin
            state    <= IDLE;
            prev_val <= 4'h0;
            prev_up  <= 1'b0;
        end else if (sample_en) begin
            case (state)
                IDLE:    state <= TRACK;
                TRACK:   state <= TRACK;
                default: state <= IDLE;
            endcase
            prev_val <= din;
            prev_up  <= up_in;
        end
    end

    // NOTE: the storage array has no reset; the read outputs are gated by
    // evt_valid, so stale contents never become visible.
    always_ff @(posedge clk) begin
        if (n_push != 2'd0) begin
            mem[wr_ptr] <= slot0;
        end
        if (n_push == 2'd2) begin
            mem[wr_ptr + AW'(1)] <= slot1;
        end
    end

    always_ff @(posedge clk or negedge rst_int) begin
        if (!rst_int) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            drop_q  <= 1'b0;
        end else begin
            wr_ptr  <= wr_ptr + AW'(n_push);
            rd_ptr  <= rd_ptr + AW'(pop);
            level_q <= level_q + LW'(n_push) - LW'(pop);
            if (drop_now) begin
                drop_q <= 1'b1;
            end
        end
    end

    // Net wrap tally clamps at the signed limits instead of rolling over.
    always_ff @(posedge clk or negedge rst_int) begin
        if (!rst_int) begin
            wrap_q <= '0;
        end else if (wrap_up && (wrap_q != WRAP_MAX)) begin
            wrap_q <= wrap_q + WRAP_W'(1);
        end else if (wrap_dn && (wrap_q != WRAP_MIN)) begin
            wrap_q <= wrap_q - WRAP_W'(1);
        end
    end

    assign evt_valid  = (level_q != '0);
    assign evt_code   = evt_valid ? mem[rd_ptr].code  : 2'b00;
    assign evt_value  = evt_valid ? mem[rd_ptr].value : 4'h0;
    assign wrap_cnt   = wrap_q;
    assign evt_drop   = drop_q;
    assign fifo_level = level_q;

endmodule

// File: tb/tb_counter_wrap_monitor.sv
// Directed bench for counter_wrap_monitor: queue-based event model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_counter_wrap_monitor;

    localparam int DEPTH  = 4;
    localparam int WRAP_W = 4;
    localparam int W_MAX  = (1 << (WRAP_W - 1)) - 1;
    localparam int W_MIN  = -(1 << (WRAP_W - 1));
    localparam int W_MASK = (1 << WRAP_W) - 1;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic [3:0]             din = 4'h0;
    logic                   up_in = 1'b0;
    logic                   sample_en = 1'b0;
    logic                   evt_ready = 1'b0;
    logic                   evt_valid;
    logic [1:0]             evt_code;
    logic [3:0]             evt_value;
    logic [WRAP_W-1:0]      wrap_cnt;
    logic                   evt_drop;
    logic [$clog2(DEPTH):0] fifo_level;

    counter_wrap_monitor #(.DEPTH(DEPTH), .WRAP_W(WRAP_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .up_in      (up_in),
        .sample_en  (sample_en),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_code   (evt_code),
        .evt_value  (evt_value),
        .wrap_cnt   (wrap_cnt),
        .evt_drop   (evt_drop),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Model: events are code*16+value in a queue capped at DEPTH entries.
    int m_q[$];
    int m_ev[$];
    int m_wrap = 0;
    bit m_drop = 1'b0;
    bit m_have = 1'b0;
    int m_prev = 0;
    bit m_prev_up = 1'b0;
    int m_diff;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_q.delete();
            m_wrap = 0;
            m_drop = 1'b0;
            m_have = 1'b0;
            m_prev = 0;
            m_prev_up = 1'b0;
        end else begin
            m_ev.delete();
            if (m_q.size() > 0 && evt_ready) void'(m_q.pop_front());
            if (sample_en) begin
                if (m_have && int'(din) != m_prev) begin
                    m_diff = (int'(din) - m_prev + 16) % 16;
                    if (m_prev == 15 && din == 0) begin
                        m_ev.push_back(0 * 16 + int'(din));
                        m_wrap = (m_wrap + 1 > W_MAX) ? W_MAX : m_wrap + 1;
                    end else if (m_prev == 0 && din == 15) begin
                        m_ev.push_back(1 * 16 + int'(din));
                        m_wrap = (m_wrap - 1 < W_MIN) ? W_MIN : m_wrap - 1;
                    end
`ifdef JUMP_CHECK_EN
                    else if (m_diff != 1 && m_diff != 15) begin
                        m_ev.push_back(3 * 16 + int'(din));
                    end
`endif
                    if (up_in != m_prev_up) m_ev.push_back(2 * 16 + int'(din));
                end
                m_have = 1'b1;
                m_prev = int'(din);
                m_prev_up = up_in;
            end
            foreach (m_ev[i]) begin
                if (m_q.size() < DEPTH) m_q.push_back(m_ev[i]);
                else m_drop = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        check("evt_valid", evt_valid, (m_q.size() != 0) ? 1 : 0);
        check("fifo_level", fifo_level, m_q.size());
        check("evt_code", evt_code, (m_q.size() != 0) ? (m_q[0] >> 4) : 0);
        check("evt_value", evt_value, (m_q.size() != 0) ? (m_q[0] & 15) : 0);
        check("wrap_cnt", wrap_cnt, m_wrap & W_MASK);
        check("evt_drop", evt_drop, m_drop);
    end

    task automatic step(input bit en, input int d, input bit up, input bit rdy);
        sample_en = en;
        din       = 4'(d);
        up_in     = up;
        evt_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    int v;

    initial begin
        // Power-on reset and synchroniser release.
        repeat (2) @(posedge clk);
        #1;
        check("rst_level", fifo_level, 0);
        check("rst_valid", evt_valid, 0);
        check("rst_code", evt_code, 0);
        check("rst_wrap", wrap_cnt, 0);
        rst = 1'b1;
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);

        // Up sweep with a single wrap-up.
        step(1, 13, 1, 1);
        step(1, 14, 1, 1);
        step(1, 15, 1, 1);
        check("up_pre_valid", evt_valid, 0);
        step(1, 0, 1, 1);
        check("up_valid", evt_valid, 1);
        check("up_code", evt_code, 0);
        check("up_value", evt_value, 0);
        check("up_wrap", wrap_cnt, 1);
        step(1, 1, 1, 1);
        check("up_popped", evt_valid, 0);

        // Down sweep with a single wrap-down; first sample is a hold.
        step(1, 1, 0, 1);
        check("hold_no_evt", evt_valid, 0);
        step(1, 0, 0, 1);
        step(1, 15, 0, 1);
        check("dn_code", evt_code, 1);
        check("dn_value", evt_value, 15);
        check("dn_wrap", wrap_cnt, 0);
        step(1, 14, 0, 1);

        // Backpressure: five wraps into four slots.
        step(1, 15, 0, 0);
        step(1, 0, 0, 0);
        step(1, 15, 0, 0);
        step(1, 0, 0, 0);
        step(1, 15, 0, 0);
        step(1, 0, 0, 0);
        check("bp_level", fifo_level, 4);
        check("bp_drop", evt_drop, 1);
        check("bp_code", evt_code, 0);
        check("bp_value", evt_value, 0);
        check("bp_wrap", wrap_cnt, 1);
        step(0, 0, 0, 0);
        check("bp_stable_code", evt_code, 0);
        check("bp_stable_value", evt_value, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
        check("bp_drained", fifo_level, 0);

        // Reset with three events queued.
        step(1, 15, 1, 0);
        step(1, 0, 1, 0);
        check("pre_rst_level", fifo_level, 3);
        rst = 1'b0;
        #1;
        check("mid_rst_level", fifo_level, 0);
        check("mid_rst_valid", evt_valid, 0);
        check("mid_rst_wrap", wrap_cnt, 0);
        check("mid_rst_drop", evt_drop, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        rst = 1'b1;
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(1, 5, 0, 1);
        check("post_rst_first", evt_valid, 0);
        step(1, 5, 0, 1);

        // Climb to 15 going up, then wrap while reversing.
        v = 5;
        for (int i = 0; i < 10; i++) begin
            v = v + 1;
            step(1, v, 1, 1);
        end
        step(0, 0, 1, 1);
        check("co_pre_empty", fifo_level, 0);
        step(1, 0, 0, 1);
        check("co_level", fifo_level, 2);
        check("co_code0", evt_code, 0);
        check("co_value0", evt_value, 0);
        step(0, 0, 0, 1);
        check("co_code1", evt_code, 2);
        check("co_value1", evt_value, 0);
        step(0, 0, 0, 1);
        check("co_drained", fifo_level, 0);

        // Coincident wrap+direction with one free slot.
        check("co_drop_clear", evt_drop, 0);
        step(1, 15, 0, 0);
        step(1, 0, 0, 0);
        step(1, 15, 0, 0);
        step(1, 0, 1, 0);
        check("one_free_level", fifo_level, 4);
        check("one_free_drop", evt_drop, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 1);

        // Jump 3 -> 9.
        step(1, 1, 1, 1);
        step(1, 2, 1, 1);
        step(1, 3, 1, 1);
        step(1, 9, 1, 1);
`ifdef JUMP_CHECK_EN
        check("jump_valid", evt_valid, 1);
        check("jump_code", evt_code, 3);
        check("jump_value", evt_value, 9);
`else
        check("jump_none", evt_valid, 0);
`endif
        step(0, 0, 1, 1);

        // Saturate the tally at both signed limits.
        v = 9;
        for (int i = 0; i < 16 * 17; i++) begin
            v = (v + 1) % 16;
            step(1, v, 1, 1);
        end
        check("sat_pos", wrap_cnt, W_MAX & W_MASK);
        for (int i = 0; i < 16 * 18; i++) begin
            v = (v + 15) % 16;
            step(1, v, 0, 1);
        end
        check("sat_neg", wrap_cnt, W_MIN & W_MASK);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
